// File: rtl/iomux_seq.sv
// Break-before-make pad function sequencer: holds changing pads' output enable low while their function mux switches.
// Optional configuration lock (lock/err ports) is built when IOMUX_SEQ_LOCK_EN is defined.
module iomux_seq #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [21:0] RESET_FN      = 22'h0
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [21:0] req_fn,
  input  logic [21:0] req_oe,
  output logic [21:0] gpio_fn,
  output logic [21:0] gpio_oe,
  output logic [21:0] pad_hold,
  output logic        busy,
  output logic        done
`ifdef IOMUX_SEQ_LOCK_EN
  ,
  input  logic        lock,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SWITCH = 2'd2,
    S_APPLY  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [21:0] fn_cap_q, fn_cap_d;
  logic [21:0] oe_cap_q, oe_cap_d;
  logic [21:0] gpio_fn_q, gpio_fn_d;
  logic [21:0] gpio_oe_q, gpio_oe_d;
  logic [21:0] pad_hold_q, pad_hold_d;
  logic        done_q, done_d;
  logic [21:0] chg_s;
  logic        accept_s;
  logic        lock_s;

`ifdef IOMUX_SEQ_LOCK_EN
  logic err_q, err_d;
  assign lock_s = lock;
  assign err    = err_q;
`else
  assign lock_s = 1'b0;
`endif

  assign accept_s  = req_valid && (state_q == S_IDLE);
  assign chg_s     = req_fn ^ gpio_fn_q;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign gpio_fn   = gpio_fn_q;
  assign gpio_oe   = gpio_oe_q;
  assign pad_hold  = pad_hold_q;
  assign done      = done_q;

  // Next-state and datapath updates for the hold/switch/apply sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fn_cap_d   = fn_cap_q;
    oe_cap_d   = oe_cap_q;
    gpio_fn_d  = gpio_fn_q;
    gpio_oe_d  = gpio_oe_q;
    pad_hold_d = pad_hold_q;
    done_d     = 1'b0;
`ifdef IOMUX_SEQ_LOCK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (lock_s) begin
`ifdef IOMUX_SEQ_LOCK_EN
            err_d = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            fn_cap_d = req_fn;
            oe_cap_d = req_oe;
            // Only pads whose function actually changes are held off.
            if (chg_s != 22'd0) begin
              pad_hold_d = chg_s;
              cnt_d      = CNT_LOAD;
              state_d    = S_HOLD;
            end else begin
              state_d = S_APPLY;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          gpio_fn_d = fn_cap_q;
          state_d   = S_SWITCH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SWITCH: begin
        state_d = S_APPLY;
      end
      S_APPLY: begin
        gpio_oe_d  = oe_cap_q;
        pad_hold_d = 22'd0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      fn_cap_q   <= 22'd0;
      oe_cap_q   <= 22'd0;
      gpio_fn_q  <= RESET_FN;
      gpio_oe_q  <= 22'd0;
      pad_hold_q <= 22'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fn_cap_q   <= fn_cap_d;
      oe_cap_q   <= oe_cap_d;
      gpio_fn_q  <= gpio_fn_d;
      gpio_oe_q  <= gpio_oe_d;
      pad_hold_q <= pad_hold_d;
      done_q     <= done_d;
    end
  end

`ifdef IOMUX_SEQ_LOCK_EN
  // Rejection pulse register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_iomux_seq.sv
// Scoreboard bench for iomux_seq: driver pushes expected timelines, a negedge monitor checks every cycle.
// The lock tests are built when IOMUX_SEQ_LOCK_EN is defined.
module tb_iomux_seq;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [21:0] req_fn = 22'd0;
  logic [21:0] req_oe = 22'd0;
  logic [21:0] gpio_fn, gpio_oe, pad_hold;
  logic        busy, done;
  logic        lock = 1'b0;
  logic        err;

  logic        d1_valid = 1'b0;
  logic        d1_ready;
  logic [21:0] d1_fn = 22'd0;
  logic [21:0] d1_oe = 22'd0;
  logic [21:0] d1_gpio_fn, d1_gpio_oe, d1_hold;
  logic        d1_busy, d1_done;
  logic        d1_err;

  iomux_seq #(.SETTLE_CYCLES(S), .RESET_FN(22'h0)) dut (
    .clk(clk), .arstn(arstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_oe(req_oe), .gpio_fn(gpio_fn), .gpio_oe(gpio_oe),
    .pad_hold(pad_hold), .busy(busy), .done(done)
`ifdef IOMUX_SEQ_LOCK_EN
    , .lock(lock), .err(err)
`endif
  );

  iomux_seq #(.SETTLE_CYCLES(1), .RESET_FN(22'h0)) dut1 (
    .clk(clk), .arstn(arstn), .req_valid(d1_valid), .req_ready(d1_ready),
    .req_fn(d1_fn), .req_oe(d1_oe), .gpio_fn(d1_gpio_fn), .gpio_oe(d1_gpio_oe),
    .pad_hold(d1_hold), .busy(d1_busy), .done(d1_done)
`ifdef IOMUX_SEQ_LOCK_EN
    , .lock(1'b0), .err(d1_err)
`endif
  );

`ifndef IOMUX_SEQ_LOCK_EN
  assign err    = 1'b0;
  assign d1_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [21:0] old_fn, new_fn, old_oe, new_oe, chg;
    int a;
    int lat;
    bit is_err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [21:0] mdl_fn = 22'd0, mdl_oe = 22'd0;
  logic [21:0] app_fn = 22'd0, app_oe = 22'd0;

  task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one request from a negedge; returns the tb cycle stamp after the accepting edge.
  task automatic send(input logic [21:0] fn, input logic [21:0] oe, input bit lk, output int acc);
    exp_t e;
    bit   rdy;
    req_fn = fn; req_oe = oe; req_valid = 1'b1;
`ifdef IOMUX_SEQ_LOCK_EN
    lock = lk;
`endif
    acc = -1;
    for (int t = 0; t < 200; t++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_accepted expected=accepted");
    end else begin
      e.old_fn = mdl_fn; e.old_oe = mdl_oe; e.a = acc;
`ifdef IOMUX_SEQ_LOCK_EN
      e.is_err = lk;
`else
      e.is_err = 1'b0;
`endif
      if (e.is_err) begin
        e.new_fn = mdl_fn; e.new_oe = mdl_oe; e.chg = 22'd0; e.lat = 1;
      end else begin
        e.new_fn = fn; e.new_oe = oe; e.chg = fn ^ mdl_fn;
        e.lat = (e.chg == 22'd0) ? 2 : S + 3;
        mdl_fn = fn; mdl_oe = oe;
      end
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=%0d expected=0 pending", q.size());
    end
  endtask

  // Monitor: compares the DUT against the expected timeline of the oldest pending request.
  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (!arstn) begin
      q.delete();
      app_fn = 22'd0;
      app_oe = 22'd0;
    end else begin
      chk("busy_vs_ready", {21'd0, busy}, {21'd0, ~req_ready});
      if (q.size() == 0) begin
        chk("idle_fn", gpio_fn, app_fn);
        chk("idle_oe", gpio_oe, app_oe);
        chk("idle_hold", pad_hold, 22'd0);
        chk("idle_done", {21'd0, done}, 22'd0);
        chk("idle_ready", {21'd0, req_ready}, 22'd1);
`ifdef IOMUX_SEQ_LOCK_EN
        chk("idle_err", {21'd0, err}, 22'd0);
`endif
      end else begin
        e = q[0];
        k = cyc - e.a + 1;
        if (e.is_err) begin
          chk("lock_fn", gpio_fn, e.old_fn);
          chk("lock_oe", gpio_oe, e.old_oe);
          chk("lock_hold", pad_hold, 22'd0);
          chk("lock_done", {21'd0, done}, 22'd0);
          chk("lock_err", {21'd0, err}, 22'd1);
        end else begin
          chk("seq_fn", gpio_fn, (e.chg != 22'd0 && k < S + 1) ? e.old_fn : e.new_fn);
          chk("seq_oe", gpio_oe, (k < e.lat) ? e.old_oe : e.new_oe);
          chk("seq_hold", pad_hold, (k < e.lat) ? e.chg : 22'd0);
          chk("seq_done", {21'd0, done}, {21'd0, (k == e.lat)});
          chk("seq_ready", {21'd0, req_ready}, {21'd0, (k == e.lat)});
`ifdef IOMUX_SEQ_LOCK_EN
          chk("seq_err", {21'd0, err}, 22'd0);
`endif
        end
        if (k >= e.lat) begin
          app_fn = e.new_fn;
          app_oe = e.new_oe;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin : drv
    int a1, a2, rc, n, gap;
    logic [21:0] fn, oe;
    bit lk;

    repeat (3) @(negedge clk);
    chk("rst_fn", gpio_fn, 22'd0);
    chk("rst_oe", gpio_oe, 22'd0);
    chk("rst_hold", pad_hold, 22'd0);
    chk("rst_ready", {21'd0, req_ready}, 22'd1);
    chk("rst_busy", {21'd0, busy}, 22'd0);
    chk("rst_done", {21'd0, done}, 22'd0);

    // Release and offer an oe-only request at once: accepted on the first edge.
    arstn = 1'b1;
    rc = cyc;
    send(22'd0, 22'h3, 1'b0, a1);
    chk("first_edge_accept", 22'(a1), 22'(rc + 1));
    wait_idle();

    // Function change on pads 8..11.
    send(22'h000F00, 22'h3, 1'b0, a1);
    wait_idle();

    // Back-to-back: second request held valid from +2, accepted in the done cycle.
    send(22'h0000F0, 22'h0C, 1'b0, a1);
    @(negedge clk);
    send(22'h0000F0, 22'hAA, 1'b0, a2);
    chk("b2b_accept", 22'(a2), 22'(a1 + S + 3));
    wait_idle();

    // SETTLE_CYCLES=1 instance: bit 21 toggles at +2, done at +4.
    d1_fn = 22'h200000; d1_oe = 22'h5; d1_valid = 1'b1;
    chk("d1_ready", {21'd0, d1_ready}, 22'd1);
    @(posedge clk);
    @(negedge clk);
    d1_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("d1_fn21", {21'd0, d1_gpio_fn[21]}, {21'd0, (k >= 2)});
      chk("d1_hold", d1_hold, (k < 4) ? 22'h200000 : 22'd0);
      chk("d1_done", {21'd0, d1_done}, {21'd0, (k == 4)});
      chk("d1_oe", d1_gpio_oe, (k >= 4) ? 22'h5 : 22'd0);
      @(negedge clk);
    end

`ifdef IOMUX_SEQ_LOCK_EN
    send(22'h1, 22'h7, 1'b1, a1);
    wait_idle();
    send(22'h1, 22'h7, 1'b0, a1);
    wait_idle();
`endif

    // Randomized requests, some back-to-back, some with no function change.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      if (n == 0) fn = mdl_fn;
      else if (n == 1) fn = mdl_fn ^ (22'd1 << $urandom_range(0, 21));
      else fn = 22'($urandom);
      oe = 22'($urandom);
`ifdef IOMUX_SEQ_LOCK_EN
      lk = ($urandom_range(0, 4) == 0);
`else
      lk = 1'b0;
`endif
      send(fn, oe, lk, a1);
      gap = $urandom_range(0, 2);
      if (gap != 0) repeat (gap * 3) @(negedge clk);
    end
    wait_idle();

    // Reset in the middle of HOLD.
    send(mdl_fn ^ 22'h0F0000, 22'h11, 1'b0, a1);
    @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    chk("midrst_fn", gpio_fn, 22'd0);
    chk("midrst_oe", gpio_oe, 22'd0);
    chk("midrst_hold", pad_hold, 22'd0);
    chk("midrst_ready", {21'd0, req_ready}, 22'd1);
    chk("midrst_busy", {21'd0, busy}, 22'd0);
    chk("midrst_done", {21'd0, done}, 22'd0);
    mdl_fn = 22'd0;
    mdl_oe = 22'd0;
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    repeat (10) @(negedge clk);
    send(22'h000003, 22'h1, 1'b0, a1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iomux_seq.md
IOMUX_SEQ -- requirements
Module: iomux_seq

Interface
REQ-001 The block SHALL have a parameter SETTLE_CYCLES, default 4, giving the break-before-make hold time in clk cycles (legal range 1..255).
REQ-002 The block SHALL have a parameter RESET_FN, default 22'h0, giving the gpio_fn value loaded at reset (0 = pad is GPIO).
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock; the block's only clock.
- arstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  a new pad configuration is offered.
- req_ready  out  1  the block can accept a request.
- req_fn  in  22  requested per-pad function select (1 = special function).
- req_oe  in  22  requested per-pad GPIO output enable.
- gpio_fn  out  22  applied function select, to iomux.
- gpio_oe  out  22  applied GPIO output enable, to iomux.
- pad_hold  out  22  per-pad force output-enable low, to iomux.
- busy  out  1  a reconfiguration is in progress.
- done  out  1  one-cycle pulse when a request has been fully applied.
- lock  in  1  configuration lock (only with IOMUX_SEQ_LOCK_EN).
- err  out  1  one-cycle pulse when a request is rejected (only with IOMUX_SEQ_LOCK_EN).

Function
REQ-004 The block SHALL implement the states IDLE, HOLD, SWITCH and APPLY.
REQ-005 req_ready SHALL be 1 only in IDLE, and busy SHALL equal NOT req_ready.
REQ-006 A request SHALL be accepted on a clk edge where req_valid=1 and req_ready=1; the block SHALL then capture req_fn and req_oe and compute chg = req_fn XOR gpio_fn.
REQ-007 On acceptance with chg=0, the block SHALL go to APPLY.
REQ-008 On acceptance with chg!=0, the block SHALL set pad_hold=chg, load the 8-bit counter with SETTLE_CYCLES-1, and go to HOLD.
REQ-009 In HOLD, the counter SHALL decrement each cycle.
REQ-010 When the counter is 0 in HOLD, the block SHALL set gpio_fn to the captured fn and go to SWITCH.
REQ-011 SWITCH SHALL last exactly one cycle, with pad_hold unchanged, and SHALL then go to APPLY.
REQ-012 The APPLY edge SHALL set gpio_oe to the captured oe, clear pad_hold, assert done for the following cycle only, and return to IDLE.
REQ-013 Timing with a change: pad_hold is visible 1 cycle after acceptance; gpio_fn changes SETTLE_CYCLES cycles after pad_hold; gpio_oe, pad_hold release and done follow 2 cycles after gpio_fn.
REQ-014 Timing without a change: gpio_oe updates and done asserts 2 cycles after acceptance, and gpio_fn and pad_hold stay unchanged.
REQ-015 Pads whose bit in chg is 0 SHALL never see pad_hold asserted and SHALL never see a gpio_fn change during the sequence.
REQ-016 req_valid asserted outside IDLE SHALL be ignored, and the request SHALL be accepted only once the block is back in IDLE.
REQ-017 Back-to-back requests SHALL be supported: a request held valid during the done cycle SHALL be accepted in that same cycle.
REQ-018 The captured fn/oe SHALL be stable for the whole sequence, independent of req_fn/req_oe changes after acceptance.

Reset
REQ-019 While arstn=0, the block SHALL asynchronously force: state=IDLE, gpio_fn=RESET_FN, gpio_oe=0, pad_hold=0, counter=0, done=0, err=0, req_ready=1, busy=0.
REQ-020 Reset asserted mid-sequence SHALL discard the captured request, with no done or err pulse afterwards.
REQ-021 Reset deassertion SHALL be synchronised externally, and the first request SHALL be accepted on the first clk edge after arstn=1.

Configuration
REQ-022 With the macro IOMUX_SEQ_LOCK_EN defined, the lock and err ports SHALL exist.
REQ-023 With IOMUX_SEQ_LOCK_EN defined, a request accepted while lock=1 SHALL be consumed in IDLE with no change to gpio_fn, gpio_oe or pad_hold, no done pulse, and err=1 for the following cycle.
REQ-024 With IOMUX_SEQ_LOCK_EN defined, lock SHALL be sampled only at acceptance, so a sequence already in progress completes normally.
REQ-025 Without IOMUX_SEQ_LOCK_EN, the lock and err ports and their logic SHALL be absent, and every request SHALL be applied.

Verification
REQ-026 The bench SHALL cover reset: assert arstn=0 mid-HOLD -> outputs immediately return to reset values; after release, req_ready=1 and no done pulse.
REQ-027 The bench SHALL cover an oe-only request with SETTLE_CYCLES=4, gpio_fn=0: req_fn=0, req_oe=22'h3 -> gpio_oe=22'h3 and done 2 cycles after acceptance; pad_hold stays 0.
REQ-028 The bench SHALL cover a function change with SETTLE_CYCLES=4: req_fn=22'h000F00 -> pad_hold=22'h000F00 at +1; gpio_fn=22'h000F00 at +5; pad_hold=0 and done at +7; pads 0-7 and 12-21 are untouched throughout.
REQ-029 The bench SHALL cover back-to-back requests: the second request held valid from +2 is accepted only in the done cycle; req_ready=0 throughout the first sequence; both requests are applied in order.
REQ-030 The bench SHALL cover SETTLE_CYCLES=1 with a one-pad change of bit 21 -> gpio_fn bit 21 toggles at +2, and done at +4.
REQ-031 The bench SHALL cover the lock feature with IOMUX_SEQ_LOCK_EN defined: lock=1 and req_fn=22'h1 -> err pulse at +1, gpio_fn unchanged, no done; repeated with lock=0 -> the request is applied normally.
